// File: rtl/cmd_request_parser.sv
// ASCII "write <addr> <data>\n" / "read <addr>\n" parser driving a simple cs/ack register bus.
// Optional build macro CMD_ERR_RESP_EN: parse errors also answer "E\n" and pulse irq.
//
// state   | meaning
// IDLE    | waiting for the first keyword character
// KEY     | matching the rest of the keyword and its trailing space
// ADDR    | collecting address hex digits
// DATA    | collecting write-data hex digits
// DISCARD | dropping bytes of a bad command up to its '\n'
// ISSUE   | cs held, waiting for ack or timeout
// RESP    | streaming the response bytes out
module cmd_request_parser #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tvalid,
  input  logic [7:0]        s_tdata,
  output logic              s_tready,
  output logic              m_tvalid,
  output logic [7:0]        m_tdata,
  input  logic              m_tready,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              we,
  output logic              cs,
  input  logic              ack,
  output logic              irq,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, KEY, ADDR, DATA, DISCARD, ISSUE, RESP} state_t;
  typedef enum logic [1:0] {RK_K, RK_T, RK_E, RK_RD} rkind_t;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(DATA_W/4 + 2);
  localparam logic [RW-1:0] RD_LAST = RW'(DATA_W/4);
  localparam logic [7:0] CH_LF = 8'h0A, CH_CR = 8'h0D, CH_SP = 8'h20;

  state_t              state_q, state_d;
  rkind_t              rkind_q, rkind_d;
  logic                is_wr_q, is_wr_d;
  logic [2:0]          kidx_q, kidx_d;
  logic [4:0]          ndig_q, ndig_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [DATA_W-1:0]   rsh_q, rsh_d;
  logic [RW-1:0]       ridx_q, ridx_d, rlast;
  logic                irq_q, irq_d;
  logic                take, bad, go_issue, end_err;
  logic [4:0]          hexd;

  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) return {1'b1, c[3:0] + 4'd9};
    return 5'd0;
  endfunction

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // keyword tail after the first letter: "rite" or "ead"
  function automatic logic [7:0] key_char(input logic wr, input logic [2:0] i);
    if (wr) begin
      case (i)
        3'd0: return 8'h72;
        3'd1: return 8'h69;
        3'd2: return 8'h74;
        3'd3: return 8'h65;
        default: return 8'h00;
      endcase
    end
    case (i)
      3'd0: return 8'h65;
      3'd1: return 8'h61;
      3'd2: return 8'h64;
      default: return 8'h00;
    endcase
  endfunction

  assign s_tready = reset & (state_q inside {IDLE, KEY, ADDR, DATA, DISCARD});
  assign take     = s_tvalid & s_tready;
  assign cs       = (state_q == ISSUE);
  assign we       = cs & is_wr_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign irq      = irq_q;
  assign rlast    = (rkind_q == RK_RD) ? RD_LAST : RW'(1);

  always_comb begin
    state_d  = state_q;
    rkind_d  = rkind_q;
    is_wr_d  = is_wr_q;
    kidx_d   = kidx_q;
    ndig_d   = ndig_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tmr_d    = tmr_q;
    rsh_d    = rsh_q;
    ridx_d   = ridx_q;
    irq_d    = 1'b0;
    err      = 1'b0;
    bad      = 1'b0;
    go_issue = 1'b0;
    end_err  = 1'b0;
    m_tvalid = (state_q == RESP);
    m_tdata  = 8'h00;
    hexd     = hex_dec(s_tdata);

    if (take && s_tdata != CH_CR) begin
      case (state_q)
        IDLE: begin
          if (s_tdata == 8'h77 || s_tdata == 8'h72) begin
            is_wr_d = (s_tdata == 8'h77);
            kidx_d  = 3'd0;
            state_d = KEY;
          end else if (s_tdata != CH_LF) begin
            bad = 1'b1;
          end
        end
        KEY: begin
          if (kidx_q == (is_wr_q ? 3'd4 : 3'd3)) begin
            if (s_tdata == CH_SP) begin
              addr_d  = '0;
              ndig_d  = 5'd0;
              state_d = ADDR;
            end else begin
              bad = 1'b1;
            end
          end else if (s_tdata == key_char(is_wr_q, kidx_q)) begin
            kidx_d = kidx_q + 3'd1;
          end else begin
            bad = 1'b1;
          end
        end
        ADDR: begin
          if (hexd[4]) begin
            if (ndig_q == 5'(ADDR_W/4)) bad = 1'b1;
            else begin
              addr_d = (addr_q << 4) | ADDR_W'(hexd[3:0]);
              ndig_d = ndig_q + 5'd1;
            end
          end else if (s_tdata == CH_SP && ndig_q != 5'd0 && is_wr_q) begin
            wdata_d = '0;
            ndig_d  = 5'd0;
            state_d = DATA;
          end else if (s_tdata == CH_LF && ndig_q != 5'd0 && !is_wr_q) begin
            go_issue = 1'b1;
          end else begin
            bad = 1'b1;
          end
        end
        DATA: begin
          if (hexd[4]) begin
            if (ndig_q == 5'(DATA_W/4)) bad = 1'b1;
            else begin
              wdata_d = (wdata_q << 4) | DATA_W'(hexd[3:0]);
              ndig_d  = ndig_q + 5'd1;
            end
          end else if (s_tdata == CH_LF && ndig_q != 5'd0) begin
            go_issue = 1'b1;
          end else begin
            bad = 1'b1;
          end
        end
        DISCARD: if (s_tdata == CH_LF) end_err = 1'b1;
        default: ;
      endcase
    end

    // a bad '\n' already terminates the command, so it must not enter DISCARD
    if (bad) begin
      err = 1'b1;
      if (s_tdata == CH_LF) end_err = 1'b1;
      else state_d = DISCARD;
    end

    if (end_err) begin
`ifdef CMD_ERR_RESP_EN
      state_d = RESP;
      rkind_d = RK_E;
      ridx_d  = '0;
`else
      state_d = IDLE;
`endif
    end

    if (go_issue) begin
      state_d = ISSUE;
      tmr_d   = TW'(ACK_TIMEOUT - 1);
    end

    if (state_q == ISSUE) begin
      if (ack) begin
        rsh_d   = rdata;
        rkind_d = is_wr_q ? RK_K : RK_RD;
        ridx_d  = '0;
        state_d = RESP;
      end else if (tmr_q == '0) begin
        err     = 1'b1;
        rkind_d = RK_T;
        ridx_d  = '0;
        state_d = RESP;
      end else begin
        tmr_d = tmr_q - TW'(1);
      end
    end

    if (state_q == RESP) begin
      case (rkind_q)
        RK_RD:   m_tdata = (ridx_q == RD_LAST) ? CH_LF : hex_chr(rsh_q[DATA_W-1 -: 4]);
        RK_K:    m_tdata = (ridx_q == '0) ? 8'h4B : CH_LF;
        RK_T:    m_tdata = (ridx_q == '0) ? 8'h54 : CH_LF;
        default: m_tdata = (ridx_q == '0) ? 8'h45 : CH_LF;
      endcase
      if (m_tready) begin
        if (ridx_q == rlast) begin
          irq_d   = 1'b1;
          state_d = IDLE;
        end else begin
          ridx_d = ridx_q + RW'(1);
          rsh_d  = rsh_q << 4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rkind_q <= RK_K;
      is_wr_q <= 1'b0;
      kidx_q  <= '0;
      ndig_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmr_q   <= '0;
      rsh_q   <= '0;
      ridx_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rkind_q <= rkind_d;
      is_wr_q <= is_wr_d;
      kidx_q  <= kidx_d;
      ndig_q  <= ndig_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmr_q   <= tmr_d;
      rsh_q   <= rsh_d;
      ridx_q  <= ridx_d;
      irq_q   <= irq_d;
    end
  end
endmodule
